// File: rtl/freq_calc_pkg.sv
// Shared types and constants for the frequency calculator: FSM state encoding,
// datapath widths and the saturation value.
package freq_calc_pkg;

  localparam int unsigned CNT_W    = 32;
  localparam int unsigned NUM_W    = 64;
  localparam int unsigned DIV_ITER = 64;

  localparam logic [CNT_W-1:0] SAT_VALUE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } state_e;

endpackage

// File: rtl/udiv_serial.sv
// Serial restoring divider: 64-bit dividend by 32-bit divisor, one quotient bit
// per clock, MSB first. done_o pulses for one cycle once the quotient is final.
module udiv_serial
  import freq_calc_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [NUM_W-1:0] dividend_i,
  input  logic [CNT_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [NUM_W-1:0] quotient_o
);

  localparam int unsigned IterW = $clog2(DIV_ITER);

  logic [CNT_W:0]   rem_q, rem_d;
  logic [NUM_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] dvs_q, dvs_d;
  logic [IterW-1:0] iter_q, iter_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // One bit wider than the remainder so the borrow doubles as the compare result.
  logic [CNT_W+1:0] shifted;
  logic [CNT_W+1:0] diff;

  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    iter_d  = iter_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    shifted = {rem_q, quo_q[NUM_W-1]};
    diff    = shifted - {2'b00, dvs_q};

    if (start_i) begin
      rem_d  = '0;
      quo_d  = dividend_i;
      dvs_d  = divisor_i;
      iter_d = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (!diff[CNT_W+1]) begin
        rem_d = diff[CNT_W:0];
        quo_d = {quo_q[NUM_W-2:0], 1'b1};
      end else begin
        rem_d = shifted[CNT_W:0];
        quo_d = {quo_q[NUM_W-2:0], 1'b0};
      end
      iter_d = iter_q + 1'b1;
      if (iter_q == IterW'(DIV_ITER - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      iter_q <= iter_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/freq_calc.sv
// Turns a {ref_sum, sig_sum} measurement word into a rounded frequency in Hz
// and presents it with the raw sums and status flags over valid/ready.
module freq_calc
  import freq_calc_pkg::*;
#(
  parameter int unsigned REF_CLK_HZ = 100_000_000
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             reg_wr_en_i,
  input  logic [63:0]      reg_wr_data_i,
  input  logic             clr_i,
  input  logic             freq_ready_i,
  output logic             freq_valid_o,
  output logic [CNT_W-1:0] freq_o,
  output logic [CNT_W-1:0] sig_sum_o,
  output logic [CNT_W-1:0] ref_sum_o,
  output logic             sat_o,
  output logic             div0_o,
  output logic             overrun_o,
  output logic             busy_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] ref_q, ref_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             sat_q, sat_d;
  logic             div0_q, div0_d;
  logic             overrun_q, overrun_d;
  logic             drop;

  logic [NUM_W-1:0] num;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [NUM_W-1:0] div_quo;

  // Adding ref/2 before dividing rounds half-up; the worst case still fits 64 bits.
  assign num = NUM_W'(sig_q) * NUM_W'(REF_CLK_HZ) + NUM_W'(ref_q >> 1);

  assign div_start = (state_q == StMul) && (ref_q != '0) && !div_busy;

  udiv_serial u_div (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .start_i    (div_start),
    .dividend_i (num),
    .divisor_i  (ref_q),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    ref_d   = ref_q;
    freq_d  = freq_q;
    sat_d   = sat_q;
    div0_d  = div0_q;
    drop    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (reg_wr_en_i) begin
          sig_d   = reg_wr_data_i[31:0];
          ref_d   = reg_wr_data_i[63:32];
          sat_d   = 1'b0;
          div0_d  = 1'b0;
          state_d = StMul;
        end
      end
      StMul: begin
        drop = reg_wr_en_i;
        // A zero divisor skips the divider but still spends one DIV cycle.
        if (ref_q == '0) div0_d = 1'b1;
        state_d = StDiv;
      end
      StDiv: begin
        drop = reg_wr_en_i;
        if (div0_q) begin
          freq_d  = SAT_VALUE;
          state_d = StDone;
        end else if (div_done) begin
          if (|div_quo[NUM_W-1:CNT_W]) begin
            freq_d = SAT_VALUE;
            sat_d  = 1'b1;
          end else begin
            freq_d = div_quo[CNT_W-1:0];
          end
          state_d = StDone;
        end
      end
      StDone: begin
        if (freq_ready_i) begin
          if (reg_wr_en_i) begin
            sig_d   = reg_wr_data_i[31:0];
            ref_d   = reg_wr_data_i[63:32];
            sat_d   = 1'b0;
            div0_d  = 1'b0;
            state_d = StMul;
          end else begin
            state_d = StIdle;
          end
        end else begin
          drop = reg_wr_en_i;
        end
      end
      default: state_d = StIdle;
    endcase

    if (drop)       overrun_d = 1'b1;
    else if (clr_i) overrun_d = 1'b0;
    else            overrun_d = overrun_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      sig_q     <= '0;
      ref_q     <= '0;
      freq_q    <= '0;
      sat_q     <= 1'b0;
      div0_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sig_q     <= sig_d;
      ref_q     <= ref_d;
      freq_q    <= freq_d;
      sat_q     <= sat_d;
      div0_q    <= div0_d;
      overrun_q <= overrun_d;
    end
  end

  assign freq_valid_o = (state_q == StDone);
  assign freq_o       = freq_q;
  assign sig_sum_o    = sig_q;
  assign ref_sum_o    = ref_q;
  assign sat_o        = sat_q && freq_valid_o;
  assign div0_o       = div0_q && freq_valid_o;
  assign overrun_o    = overrun_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_freq_calc.sv
// Directed bench for freq_calc: main instance at 100 MHz reference and a second
// instance at REF_CLK_HZ=100 for the small rounding cases.
module tb_freq_calc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [63:0] wr_data;
  logic        clr;
  logic        ready;

  logic        valid, sat, div0, overrun, busy;
  logic [31:0] freq, sig_sum, ref_sum;
  logic        r_valid, r_sat, r_div0, r_overrun, r_busy;
  logic [31:0] r_freq, r_sig_sum, r_ref_sum;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  freq_calc #(.REF_CLK_HZ(100_000_000)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .reg_wr_en_i   (wr_en),
    .reg_wr_data_i (wr_data),
    .clr_i         (clr),
    .freq_ready_i  (ready),
    .freq_valid_o  (valid),
    .freq_o        (freq),
    .sig_sum_o     (sig_sum),
    .ref_sum_o     (ref_sum),
    .sat_o         (sat),
    .div0_o        (div0),
    .overrun_o     (overrun),
    .busy_o        (busy)
  );

  freq_calc #(.REF_CLK_HZ(100)) dut_r (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .reg_wr_en_i   (wr_en),
    .reg_wr_data_i (wr_data),
    .clr_i         (clr),
    .freq_ready_i  (ready),
    .freq_valid_o  (r_valid),
    .freq_o        (r_freq),
    .sig_sum_o     (r_sig_sum),
    .ref_sum_o     (r_ref_sum),
    .sat_o         (r_sat),
    .div0_o        (r_div0),
    .overrun_o     (r_overrun),
    .busy_o        (r_busy)
  );

  task automatic send(input logic [31:0] r, input logic [31:0] s);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = {r, s};
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  // Edges counted after the capture edge until valid is seen; -1 on timeout.
  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; clr = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (freq !== 32'd0) begin errors++; $display("FAIL reset_freq: got %h want 0", freq); end
    checks++; if ({sig_sum, ref_sum} !== 64'd0) begin errors++; $display("FAIL reset_sums: got %h want 0", {sig_sum, ref_sum}); end
    checks++; if ({sat, div0, overrun, busy} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {sat, div0, overrun, busy}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int n;
    send(32'd100_000, 32'd1_000);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_valid(n);
    checks++; if (n != 66) begin errors++; $display("FAIL basic_latency: got %0d want 66", n); end
    checks++; if (freq !== 32'd1_000_000) begin errors++; $display("FAIL basic_freq: got %0d want 1000000", freq); end
    checks++; if ({sat, div0} !== 2'b00) begin errors++; $display("FAIL basic_flags: got %b want 00", {sat, div0}); end
    checks++; if (sig_sum !== 32'd1_000 || ref_sum !== 32'd100_000) begin
      errors++; $display("FAIL basic_sums: got %0d/%0d want 1000/100000", sig_sum, ref_sum);
    end
    @(posedge clk);
    #1;
    checks++; if ({valid, busy} !== 2'b00) begin errors++; $display("FAIL basic_accept: got %b want 00", {valid, busy}); end
  endtask

  task automatic test_rounding();
    int n;
    send(32'd3, 32'd2);
    wait_valid(n);
    checks++; if (r_freq !== 32'd67) begin errors++; $display("FAIL round_2_3: got %0d want 67", r_freq); end
    checks++; if (freq !== 32'd66_666_667) begin errors++; $display("FAIL round_2_3_100m: got %0d want 66666667", freq); end
    @(posedge clk);
    #1;
    send(32'd3, 32'd1);
    wait_valid(n);
    checks++; if (r_freq !== 32'd33) begin errors++; $display("FAIL round_1_3: got %0d want 33", r_freq); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturation();
    int n;
    send(32'd1, 32'hFFFF_FFFF);
    wait_valid(n);
    checks++; if (freq !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_freq: got %h want ffffffff", freq); end
    checks++; if ({sat, div0} !== 2'b10) begin errors++; $display("FAIL sat_flags: got %b want 10", {sat, div0}); end
    @(posedge clk);
    #1;
    send(32'd0, 32'd5);
    wait_valid(n);
    checks++; if (n != 2) begin errors++; $display("FAIL div0_latency: got %0d want 2", n); end
    checks++; if (freq !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_freq: got %h want ffffffff", freq); end
    checks++; if ({sat, div0} !== 2'b01) begin errors++; $display("FAIL div0_flags: got %b want 01", {sat, div0}); end
    @(posedge clk);
    #1;
    send(32'd7, 32'd0);
    wait_valid(n);
    checks++; if (freq !== 32'd0 || sat !== 1'b0) begin errors++; $display("FAIL zero_sig: got %0d sat %b want 0 sat 0", freq, sat); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_overrun();
    int n;
    logic stable;
    @(negedge clk);
    ready = 1'b0;
    send(32'd100_000, 32'd2_000);
    wait_valid(n);
    checks++; if (freq !== 32'd2_000_000) begin errors++; $display("FAIL ovr_first: got %0d want 2000000", freq); end
    stable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      wr_en   = (i == 50);
      wr_data = {32'd50, 32'd1};
      @(posedge clk);
      #1;
      if (!valid || freq !== 32'd2_000_000 || sig_sum !== 32'd2_000) stable = 1'b0;
    end
    wr_en = 1'b0;
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL ovr_stable: got %b want 1", stable); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
    @(negedge clk);
    wr_en = 1'b1; clr = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0; clr = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_drop_wins: got %b want 1", overrun); end
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    checks++; if (overrun !== 1'b0 || valid !== 1'b1) begin
      errors++; $display("FAIL ovr_clear: got ovr %b valid %b want 0 1", overrun, valid);
    end
    @(negedge clk);
    ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_accept: got %b want 0", valid); end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    ready = 1'b0;
    send(32'd100_000, 32'd3_000);
    wait_valid(n);
    checks++; if (freq !== 32'd3_000_000) begin errors++; $display("FAIL b2b_first: got %0d want 3000000", freq); end
    @(negedge clk);
    ready   = 1'b1;
    wr_en   = 1'b1;
    wr_data = {32'd100_000, 32'd4_000};
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    checks++; if ({valid, busy, overrun} !== 3'b010) begin
      errors++; $display("FAIL b2b_capture: got %b want 010", {valid, busy, overrun});
    end
    wait_valid(n);
    checks++; if (n != 66) begin errors++; $display("FAIL b2b_latency: got %0d want 66", n); end
    checks++; if (freq !== 32'd4_000_000 || sig_sum !== 32'd4_000) begin
      errors++; $display("FAIL b2b_second: got %0d/%0d want 4000000/4000", freq, sig_sum);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_div();
    int n;
    logic seen;
    send(32'd100_000, 32'd5_000);
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = {32'd9, 32'd9};
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL div_drop: got %b want 1", overrun); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({valid, busy, overrun, sat, div0} !== 5'b0 || {freq, sig_sum, ref_sum} !== 96'd0) begin
      errors++; $display("FAIL async_reset: got %b %h want all zero", {valid, busy, overrun, sat, div0}, {freq, sig_sum, ref_sum});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_no_result: got %b want 0", seen); end
    send(32'd100_000, 32'd6_000);
    wait_valid(n);
    checks++; if (n != 66 || freq !== 32'd6_000_000) begin
      errors++; $display("FAIL post_reset: got lat %0d freq %0d want 66 6000000", n, freq);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_overrun();
    test_back_to_back();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
